// File: rtl/ktms_afu_track_frzctl_if.sv
// Bundle of tracking-freeze control signals: event/write inputs
// and registered status outputs. master drives i_*, slave drives o_*.
interface ktms_afu_track_frzctl_if #(
  parameter int tag_width = 1,
  parameter int cnt_width = 16
);
  logic                 i_err_v;
  logic [tag_width-1:0] i_err_tag;
  logic                 i_cmpl_v;
  logic                 i_wr_v;
  logic                 i_wr_addr;
  logic [0:63]          i_wr_d;
  logic                 o_wr_ack;
  logic                 o_freeze;
  logic [1:0]           o_state;
  logic [tag_width-1:0] o_trig_tag;
  logic [cnt_width-1:0] o_post_rem;
  logic [cnt_width-1:0] o_err_cnt;

  modport master (
    output i_err_v, i_err_tag, i_cmpl_v,
    output i_wr_v, i_wr_addr, i_wr_d,
    input  o_wr_ack, o_freeze, o_state,
    input  o_trig_tag, o_post_rem, o_err_cnt
  );

  modport slave (
    input  i_err_v, i_err_tag, i_cmpl_v,
    input  i_wr_v, i_wr_addr, i_wr_d,
    output o_wr_ack, o_freeze, o_state,
    output o_trig_tag, o_post_rem, o_err_cnt
  );
endinterface

// File: rtl/ktms_afu_track_frzctl.sv
// Freeze controller for AFU tracking memories: arm, trigger on error or
// manual write, count post-trigger completions, then freeze until clear.
// Ports: clk, reset (async, active high), bus (slave modport).
module ktms_afu_track_frzctl #(
  parameter int tag_width = 1,
  parameter int cnt_width = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  ktms_afu_track_frzctl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ARMED  = 2'b01,
    S_TRIG   = 2'b10,
    S_FROZEN = 2'b11
  } state_t;

  state_t               r_state, w_state_nx;
  logic [tag_width-1:0] r_tag, w_tag_nx;
  logic [cnt_width-1:0] r_rem, w_rem_nx;
  logic [cnt_width-1:0] r_err, w_err_nx;
  logic [cnt_width-1:0] r_n;
  logic                 r_ack;
  logic                 r_freeze;

  logic w_ctl, w_cnt_wr, w_arm, w_clr, w_trig;
  logic w_unused;

  // Write data is big-endian numbered: bit 63 is the LSB.
  assign w_ctl    = bus.i_wr_v & ~bus.i_wr_addr;
  assign w_cnt_wr = bus.i_wr_v &  bus.i_wr_addr;
  assign w_arm    = w_ctl & bus.i_wr_d[63];
  assign w_clr    = w_ctl & bus.i_wr_d[62];
  assign w_trig   = bus.i_err_v | (w_ctl & bus.i_wr_d[61]);
  assign w_unused = ^bus.i_wr_d[0:60];

  always_comb begin
    w_state_nx = r_state;
    w_tag_nx   = r_tag;
    w_rem_nx   = r_rem;
    w_err_nx   = r_err;
    if (bus.i_err_v && (r_err != '1))
      w_err_nx = r_err + 1'b1;
    if (w_clr) begin
      w_state_nx = w_arm ? S_ARMED : S_IDLE;
      w_tag_nx   = '0;
      w_rem_nx   = '0;
      w_err_nx   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_arm)
            w_state_nx = S_ARMED;
        end
        S_ARMED: begin
          // Completion in the trigger cycle is not applied to the
          // freshly loaded count.
          if (w_trig) begin
            w_tag_nx = bus.i_err_v ? bus.i_err_tag : '0;
            w_rem_nx = r_n;
            w_state_nx = (r_n == '0) ? S_FROZEN : S_TRIG;
          end
        end
        S_TRIG: begin
          if (bus.i_cmpl_v) begin
            w_rem_nx = r_rem - 1'b1;
            if (r_rem == cnt_width'(1))
              w_state_nx = S_FROZEN;
          end
        end
        S_FROZEN: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_tag    <= '0;
      r_rem    <= '0;
      r_err    <= '0;
      r_n      <= '0;
      r_ack    <= 1'b0;
      r_freeze <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_tag    <= w_tag_nx;
      r_rem    <= w_rem_nx;
      r_err    <= w_err_nx;
      r_ack    <= bus.i_wr_v;
      r_freeze <= (w_state_nx == S_FROZEN);
      // Old N is already consumed by a coincident trigger.
      if (w_cnt_wr)
        r_n <= bus.i_wr_d[64-cnt_width:63];
    end
  end

  assign bus.o_state    = r_state;
  assign bus.o_trig_tag = r_tag;
  assign bus.o_post_rem = r_rem;
  assign bus.o_err_cnt  = r_err;
  assign bus.o_wr_ack   = r_ack;
  assign bus.o_freeze   = r_freeze;

endmodule

// File: tb/tb_ktms_afu_track_frzctl.sv
// Scoreboard bench for ktms_afu_track_frzctl: expectations queued with
// stimulus, popped and compared one cycle later.
module tb_ktms_afu_track_frzctl;

  typedef enum int {
    F_STATE, F_FRZ, F_TAG, F_REM, F_ERR, F_ACK, F_ERR2, F_STATE2
  } fld_e;

  typedef struct {
    string       tag;
    fld_e        f;
    logic [63:0] v;
  } exp_t;

  localparam logic [63:0] ARM = 64'd1;
  localparam logic [63:0] CLR = 64'd2;
  localparam logic [63:0] TRG = 64'd4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sbq[$];

  ktms_afu_track_frzctl_if #(.tag_width(3), .cnt_width(16)) ifa ();
  ktms_afu_track_frzctl_if #(.tag_width(3), .cnt_width(2))  ifb ();

  ktms_afu_track_frzctl #(.tag_width(3), .cnt_width(16)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave)
  );
  ktms_afu_track_frzctl #(.tag_width(3), .cnt_width(2)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  function automatic logic [63:0] get(fld_e f);
    case (f)
      F_STATE:  return 64'(ifa.o_state);
      F_FRZ:    return 64'(ifa.o_freeze);
      F_TAG:    return 64'(ifa.o_trig_tag);
      F_REM:    return 64'(ifa.o_post_rem);
      F_ERR:    return 64'(ifa.o_err_cnt);
      F_ACK:    return 64'(ifa.o_wr_ack);
      F_ERR2:   return 64'(ifb.o_err_cnt);
      default:  return 64'(ifb.o_state);
    endcase
  endfunction

  task automatic e(string t, fld_e f, logic [63:0] v);
    sbq.push_back('{t, f, v});
  endtask

  task automatic drain();
    exp_t x;
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      chk(x.tag, get(x.f), x.v);
    end
  endtask

  task automatic idle_in();
    ifa.i_err_v = 0; ifa.i_err_tag = 0; ifa.i_cmpl_v = 0;
    ifa.i_wr_v = 0; ifa.i_wr_addr = 0; ifa.i_wr_d = '0;
    ifb.i_err_v = 0; ifb.i_err_tag = 0; ifb.i_cmpl_v = 0;
    ifb.i_wr_v = 0; ifb.i_wr_addr = 0; ifb.i_wr_d = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_in();
    drain();
  endtask

  task automatic wr(logic a, logic [63:0] d);
    ifa.i_wr_v = 1; ifa.i_wr_addr = a; ifa.i_wr_d = d;
  endtask

  task automatic err(logic [2:0] t);
    ifa.i_err_v = 1; ifa.i_err_tag = t;
  endtask

  initial begin
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    e("rst_state", F_STATE, 0); e("rst_frz", F_FRZ, 0);
    e("rst_tag", F_TAG, 0); e("rst_rem", F_REM, 0);
    e("rst_err", F_ERR, 0); e("rst_ack", F_ACK, 0);
    e("rst_err2", F_ERR2, 0);
    drain();
    reset = 0;

    // N=0, arm, error tag 5 -> frozen
    wr(1, 64'd0); e("n0_ack", F_ACK, 1); e("n0_st", F_STATE, 0); tick();
    e("noack", F_ACK, 0); tick();
    wr(0, ARM); e("arm_st", F_STATE, 1); tick();
    err(5);
    e("f_st", F_STATE, 3); e("f_frz", F_FRZ, 1);
    e("f_tag", F_TAG, 5); e("f_err", F_ERR, 1); tick();
    wr(0, ARM); e("fa_st", F_STATE, 3); e("fa_frz", F_FRZ, 1); tick();
    ifa.i_cmpl_v = 1; e("fc_st", F_STATE, 3); e("fc_rem", F_REM, 0); tick();
    wr(0, ARM | CLR);
    e("ca_st", F_STATE, 1); e("ca_frz", F_FRZ, 0);
    e("ca_err", F_ERR, 0); e("ca_tag", F_TAG, 0); tick();

    // N=3 post-trigger countdown
    wr(1, 64'd3); e("n3_st", F_STATE, 1); tick();
    err(2);
    e("t_st", F_STATE, 2); e("t_rem", F_REM, 3);
    e("t_tag", F_TAG, 2); e("t_err", F_ERR, 1); e("t_frz", F_FRZ, 0); tick();
    ifa.i_cmpl_v = 1; e("c1_rem", F_REM, 2); tick();
    e("gap_rem", F_REM, 2); tick();
    err(7);
    e("re_tag", F_TAG, 2); e("re_err", F_ERR, 2); e("re_st", F_STATE, 2); tick();
    ifa.i_cmpl_v = 1; e("c2_rem", F_REM, 1); e("c2_frz", F_FRZ, 0); tick();
    tick();
    ifa.i_cmpl_v = 1;
    e("c3_rem", F_REM, 0); e("c3_st", F_STATE, 3); e("c3_frz", F_FRZ, 1); tick();

    // Trigger with completion in same cycle keeps loaded N
    wr(0, ARM | CLR); e("ca2_st", F_STATE, 1); e("ca2_err", F_ERR, 0); tick();
    wr(0, TRG); ifa.i_cmpl_v = 1;
    e("tc_st", F_STATE, 2); e("tc_rem", F_REM, 3); e("tc_tag", F_TAG, 0); tick();

    // Clear beats a coincident error
    wr(0, CLR); err(6);
    e("ce_st", F_STATE, 0); e("ce_err", F_ERR, 0);
    e("ce_tag", F_TAG, 0); e("ce_rem", F_REM, 0); tick();
    err(1); e("ie_st", F_STATE, 0); e("ie_err", F_ERR, 1); tick();
    wr(0, ARM); e("arm2_st", F_STATE, 1); tick();

    // Count write with trigger uses old N (3)
    wr(1, 64'd1); err(4);
    e("ow_st", F_STATE, 2); e("ow_rem", F_REM, 3);
    e("ow_tag", F_TAG, 4); e("ow_err", F_ERR, 2); tick();
    for (int i = 2; i >= 0; i--) begin
      ifa.i_cmpl_v = 1; e("ow_cnt", F_REM, 64'(i)); tick();
    end
    e("ow_frz", F_FRZ, 1); e("ow_fst", F_STATE, 3); tick();

    // New N=1; manual + error trigger together count once
    wr(0, ARM | CLR); e("ca3_st", F_STATE, 1); tick();
    wr(0, TRG); err(3);
    e("dt_st", F_STATE, 2); e("dt_rem", F_REM, 1);
    e("dt_tag", F_TAG, 3); e("dt_err", F_ERR, 1); tick();
    ifa.i_cmpl_v = 1;
    e("n1_st", F_STATE, 3); e("n1_frz", F_FRZ, 1); e("n1_rem", F_REM, 0); tick();

    // Async reset mid-cycle while frozen
    #3;
    reset = 1;
    #1;
    e("ar_frz", F_FRZ, 0); e("ar_st", F_STATE, 0);
    e("ar_tag", F_TAG, 0); e("ar_err", F_ERR, 0);
    e("ar_rem", F_REM, 0); e("ar_ack", F_ACK, 0);
    drain();
    #1;
    reset = 0;
    e("pr_st", F_STATE, 0); e("pr_frz", F_FRZ, 0); tick();
    wr(0, ARM); tick();
    err(1); e("nr_st", F_STATE, 3); e("nr_rem", F_REM, 0); tick();

    // Saturating error counter, width 2
    for (int i = 1; i <= 5; i++) begin
      ifb.i_err_v = 1; ifb.i_err_tag = 3'(i);
      e("sat_err", F_ERR2, 64'(i > 3 ? 3 : i));
      e("sat_st", F_STATE2, 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
